hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, range 1..3, source operands per instruction.
REQ-003 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port i_ifid_Src  in  NUM_SRC*REG_AW  source register numbers of the decode-stage instruction; slot k at bits [k*REG_AW +: REG_AW].
REQ-007 SHALL have port i_ifid_SrcVld  in  NUM_SRC  per-slot "source is read" flag.
REQ-008 SHALL have port i_idex_Src  in  NUM_SRC*REG_AW  source register numbers of the execute-stage instruction.
REQ-009 SHALL have ports i_idex_RegDst  in  REG_AW, i_idex_RegWrEn  in  1, i_idex_MemToReg  in  1: destination register, write enable and load flag of the execute-stage instruction.
REQ-010 SHALL have ports i_exm_RegDst  in  REG_AW, i_exm_RegWrEn  in  1: destination and write enable in the EX/MEM register.
REQ-011 SHALL have ports i_mwb_RegDst  in  REG_AW, i_mwb_RegWrEn  in  1: destination and write enable in the MEM/WB register.
REQ-012 SHALL have port i_redirect  in  1  taken branch/jump resolved in the memory stage.
REQ-013 SHALL have port i_dmem_busy  in  1  data memory not ready this cycle.
REQ-014 SHALL have port o_stall  out  4  hold enables; bit0 PC/IF, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM.
REQ-015 SHALL have port o_flush  out  3  squash enables; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM.
REQ-016 SHALL have port o_fwd_Slct  out  2*NUM_SRC  per execute-stage source select: 00 = register file, 01 = EX/MEM result, 10 = writeback data.
REQ-017 SHALL have ports o_state  out  2, o_stall_cnt  out  CNT_W, o_flush_cnt  out  CNT_W.

Function
REQ-018 Forwarding select for slot k SHALL be combinational.
- 01 when i_exm_RegWrEn, i_exm_RegDst != 0 and i_exm_RegDst equals the slot-k source.
- Otherwise 10 when the same three conditions hold for i_mwb_*.
- Otherwise 00.
- EX/MEM has priority over MEM/WB.
REQ-019 Load-use hazard SHALL be true when all of the following hold: i_idex_MemToReg, i_idex_RegWrEn, i_idex_RegDst != 0, and for some k, i_ifid_SrcVld[k] with i_ifid_Src slot k equal to i_idex_RegDst.
REQ-020 The FSM SHALL have states RUN=00, MEMW=01, REPLAY=10; o_state SHALL equal the current state; encoding 11 SHALL return to RUN on the next edge.
REQ-021 RUN, i_dmem_busy=1: o_stall=4'b1111, o_flush=000; next state MEMW. If i_redirect=1 in that cycle, set the pending flag.
REQ-022 RUN, i_dmem_busy=0, i_redirect=1: o_flush=3'b111, o_stall=0000, in the same cycle; the load-use hazard is ignored.
REQ-023 RUN, no busy, no redirect, load-use hazard: o_stall=4'b0011 and o_flush=3'b010 (bubble into ID/EX) for exactly that cycle.
REQ-024 MEMW: o_stall=4'b1111 and o_flush=000 while i_dmem_busy=1; i_redirect=1 sets the pending flag.
REQ-025 MEMW, on the cycle i_dmem_busy falls:
- pending flag set: o_stall=0000, o_flush=000; next state REPLAY.
- pending flag clear: behave as RUN for that cycle; next state RUN.
REQ-026 REPLAY: o_flush=3'b111, o_stall=0000 for one cycle; clear the pending flag; next state RUN. An i_dmem_busy=1 in REPLAY SHALL take effect the following cycle.
REQ-027 o_stall_cnt SHALL increment on every cycle with o_stall[0]=1; o_flush_cnt SHALL increment on every cycle with o_flush[0]=1; both SHALL saturate at all-ones and never wrap.
REQ-028 Register 0 SHALL never cause forwarding or a load-use stall.

Reset
REQ-029 With reset=0 sampled at a rising edge, the block SHALL set state RUN, pending flag 0, and both counters 0.
REQ-030 During reset=0 the block SHALL drive o_stall=0000 and o_flush=000, regardless of inputs; o_fwd_Slct stays combinational.
REQ-031 Reset asserted during MEMW or REPLAY SHALL discard any pending redirect.

Verification
REQ-032 Load x5 in EX (MemToReg=1, RegDst=5), decode reads x5 -> one cycle of o_stall=0011, o_flush=010; o_stall_cnt=1.
REQ-033 EX/MEM and MEM/WB both write x7, execute source0=7 -> o_fwd_Slct[1:0]=01; with EX/MEM RegWrEn=0 -> 10; with RegDst=0 on both -> 00.
REQ-034 i_redirect=1 concurrent with a load-use hazard in RUN -> o_flush=111, o_stall=0000; o_flush_cnt=1.
REQ-035 i_dmem_busy high 3 cycles with i_redirect rising in the 2nd cycle -> o_stall=1111 for 3 cycles, then one cycle of 0000/000, then REPLAY with o_flush=111, then RUN.
REQ-036 Force o_stall_cnt to all-ones by holding busy 2^CNT_W cycles (CNT_W=4 build) -> the count stays at 15; reset=0 mid-MEMW -> state 00, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use bubbles,
// data-memory wait stalls with deferred redirect replay, and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*REG_AW-1:0]   i_ifid_Src,
    input  logic [NUM_SRC-1:0]          i_ifid_SrcVld,
    input  logic [NUM_SRC*REG_AW-1:0]   i_idex_Src,
    input  logic [REG_AW-1:0]           i_idex_RegDst,
    input  logic                        i_idex_RegWrEn,
    input  logic                        i_idex_MemToReg,
    input  logic [REG_AW-1:0]           i_exm_RegDst,
    input  logic                        i_exm_RegWrEn,
    input  logic [REG_AW-1:0]           i_mwb_RegDst,
    input  logic                        i_mwb_RegWrEn,
    input  logic                        i_redirect,
    input  logic                        i_dmem_busy,
    output logic [3:0]                  o_stall,
    output logic [2:0]                  o_flush,
    output logic [2*NUM_SRC-1:0]        o_fwd_Slct,
    output logic [1:0]                  o_state,
    output logic [CNT_W-1:0]            o_stall_cnt,
    output logic [CNT_W-1:0]            o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_MEMW   = 2'b01,
        ST_REPLAY = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_pend;
    logic               w_pend_next;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [3:0]         w_stall;
    logic [2:0]         w_flush;
    logic [NUM_SRC-1:0] w_lu_match;
    logic               w_load_use;

    logic w_exm_wr;
    logic w_mwb_wr;
    assign w_exm_wr = i_exm_RegWrEn && (i_exm_RegDst != '0);
    assign w_mwb_wr = i_mwb_RegWrEn && (i_mwb_RegDst != '0);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_AW-1:0] w_ex_src;
        assign w_ex_src = i_idex_Src[gi*REG_AW +: REG_AW];
        // EX/MEM holds the younger result, so it wins over MEM/WB.
        assign o_fwd_Slct[2*gi +: 2] =
            (w_exm_wr && (i_exm_RegDst == w_ex_src)) ? 2'b01 :
            (w_mwb_wr && (i_mwb_RegDst == w_ex_src)) ? 2'b10 : 2'b00;
        assign w_lu_match[gi] = i_ifid_SrcVld[gi] &&
                                (i_ifid_Src[gi*REG_AW +: REG_AW] == i_idex_RegDst);
    end

    assign w_load_use = i_idex_MemToReg && i_idex_RegWrEn &&
                        (i_idex_RegDst != '0) && (|w_lu_match);

    always_comb begin
        w_stall      = 4'b0000;
        w_flush      = 3'b000;
        w_state_next = r_state;
        w_pend_next  = r_pend;
        case (r_state)
            ST_RUN: begin
                if (i_dmem_busy) begin
                    w_stall      = 4'b1111;
                    w_state_next = ST_MEMW;
                    if (i_redirect) w_pend_next = 1'b1;
                end else if (i_redirect) begin
                    w_flush = 3'b111;
                end else if (w_load_use) begin
                    w_stall = 4'b0011;
                    w_flush = 3'b010;
                end
            end
            ST_MEMW: begin
                if (i_dmem_busy) begin
                    w_stall = 4'b1111;
                    if (i_redirect) w_pend_next = 1'b1;
                end else if (r_pend) begin
                    w_state_next = ST_REPLAY;
                end else begin
                    // Memory released with nothing deferred: act exactly like RUN.
                    w_state_next = ST_RUN;
                    if (i_redirect) begin
                        w_flush = 3'b111;
                    end else if (w_load_use) begin
                        w_stall = 4'b0011;
                        w_flush = 3'b010;
                    end
                end
            end
            ST_REPLAY: begin
                w_flush      = 3'b111;
                w_pend_next  = 1'b0;
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
        if (!reset) begin
            w_stall = 4'b0000;
            w_flush = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_pend      <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            if (w_stall[0] && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_flush[0] && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_stall     = w_stall;
    assign o_flush     = w_flush;
    assign o_state     = r_state;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=4 build): expected outputs are queued per cycle
// by the driver and checked by an independent monitor on the falling edge.
module tb_hazard_ctrl;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ifid_src;
    logic [1:0]  ifid_vld;
    logic [9:0]  idex_src;
    logic [4:0]  idex_dst;
    logic        idex_wr;
    logic        idex_m2r;
    logic [4:0]  exm_dst;
    logic        exm_wr;
    logic [4:0]  mwb_dst;
    logic        mwb_wr;
    logic        redirect;
    logic        busy;
    logic [3:0]  o_stall;
    logic [2:0]  o_flush;
    logic [3:0]  o_fwd;
    logic [1:0]  o_state;
    logic [3:0]  o_scnt;
    logic [3:0]  o_fcnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .i_ifid_Src(ifid_src), .i_ifid_SrcVld(ifid_vld),
        .i_idex_Src(idex_src), .i_idex_RegDst(idex_dst),
        .i_idex_RegWrEn(idex_wr), .i_idex_MemToReg(idex_m2r),
        .i_exm_RegDst(exm_dst), .i_exm_RegWrEn(exm_wr),
        .i_mwb_RegDst(mwb_dst), .i_mwb_RegWrEn(mwb_wr),
        .i_redirect(redirect), .i_dmem_busy(busy),
        .o_stall(o_stall), .o_flush(o_flush), .o_fwd_Slct(o_fwd),
        .o_state(o_state), .o_stall_cnt(o_scnt), .o_flush_cnt(o_fcnt)
    );

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [2:0] fl;
        logic [1:0] state;
        logic [3:0] fwd;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifid_src = '0; ifid_vld = '0; idex_src = '0; idex_dst = '0;
        idex_wr = 0; idex_m2r = 0; exm_dst = '0; exm_wr = 0;
        mwb_dst = '0; mwb_wr = 0; redirect = 0; busy = 0;
    endtask

    task automatic push(input string nm, input logic [3:0] st, input logic [2:0] fl,
                        input logic [1:0] s, input logic [3:0] fw, input int sc, input int fc);
        exp_t e;
        e.name = nm; e.st = st; e.fl = fl; e.state = s; e.fwd = fw;
        e.sc = 4'(sc); e.fc = 4'(fc);
        exp_q.push_back(e);
    endtask

    task automatic load_use(input logic [4:0] dst);
        idex_m2r = 1; idex_wr = 1; idex_dst = dst;
        ifid_src = {5'd0, dst}; ifid_vld = 2'b01;
    endtask

    // Monitor: consumes one expectation per cycle, independent of the driver.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if ({o_stall, o_flush, o_state} !== {e.st, e.fl, e.state}) begin
                    n_fail++;
                    $display("FAIL %s ctrl: got stall=%b flush=%b state=%b, want stall=%b flush=%b state=%b",
                             e.name, o_stall, o_flush, o_state, e.st, e.fl, e.state);
                end
                n_chk++;
                if (o_fwd !== e.fwd) begin
                    n_fail++;
                    $display("FAIL %s fwd: got %b want %b", e.name, o_fwd, e.fwd);
                end
                n_chk++;
                if ({o_scnt, o_fcnt} !== {e.sc, e.fc}) begin
                    n_fail++;
                    $display("FAIL %s cnt: got stall_cnt=%0d flush_cnt=%0d want %0d %0d",
                             e.name, o_scnt, o_fcnt, e.sc, e.fc);
                end
                $display("%0t %s stall=%b flush=%b state=%b fwd=%b cnt=%0d/%0d",
                         $time, e.name, o_stall, o_flush, o_state, o_fwd, o_scnt, o_fcnt);
            end
        end
    end

    initial begin
        idle();
        reset = 0;
        // Reset held with busy/redirect active: outputs forced quiet.
        tick(); busy = 1; redirect = 1;
        push("reset_quiet", 4'b0000, 3'b000, 2'b00, 4'b0000, 0, 0);
        tick(); idle(); reset = 1;
        push("idle", 4'b0000, 3'b000, 2'b00, 4'b0000, 0, 0);

        tick(); idle(); load_use(5'd5);
        push("lu_x5", 4'b0011, 3'b010, 2'b00, 4'b0000, 0, 0);
        tick(); idle();
        push("after_lu", 4'b0000, 3'b000, 2'b00, 4'b0000, 1, 0);
        tick(); idle(); idex_m2r = 1; idex_wr = 1; idex_dst = 5'd9;
        ifid_src = {5'd9, 5'd3}; ifid_vld = 2'b10;
        push("lu_slot1", 4'b0011, 3'b010, 2'b00, 4'b0000, 1, 0);
        tick(); ifid_vld = 2'b01;
        push("lu_slot1_notvld", 4'b0000, 3'b000, 2'b00, 4'b0000, 2, 0);
        tick(); idle(); load_use(5'd0); ifid_vld = 2'b11;
        push("lu_x0", 4'b0000, 3'b000, 2'b00, 4'b0000, 2, 0);
        tick(); idle(); load_use(5'd9); idex_m2r = 0;
        push("lu_not_load", 4'b0000, 3'b000, 2'b00, 4'b0000, 2, 0);

        tick(); idle(); exm_dst = 5'd7; exm_wr = 1; mwb_dst = 5'd7; mwb_wr = 1;
        idex_src = {5'd0, 5'd7};
        push("fwd_exm_prio", 4'b0000, 3'b000, 2'b00, 4'b0001, 2, 0);
        tick(); exm_wr = 0;
        push("fwd_mwb", 4'b0000, 3'b000, 2'b00, 4'b0010, 2, 0);
        tick(); exm_wr = 1; exm_dst = 5'd0; mwb_dst = 5'd0; idex_src = '0;
        push("fwd_x0", 4'b0000, 3'b000, 2'b00, 4'b0000, 2, 0);
        tick(); exm_dst = 5'd7; mwb_dst = 5'd12; idex_src = {5'd12, 5'd7};
        push("fwd_mixed", 4'b0000, 3'b000, 2'b00, 4'b1001, 2, 0);

        tick(); idle(); load_use(5'd5); redirect = 1;
        push("redir_lu", 4'b0000, 3'b111, 2'b00, 4'b0000, 2, 0);
        tick(); idle();
        push("after_redir", 4'b0000, 3'b000, 2'b00, 4'b0000, 2, 1);

        // Busy for three cycles, redirect in the second: deferred replay.
        tick(); busy = 1;
        push("memw_1", 4'b1111, 3'b000, 2'b00, 4'b0000, 2, 1);
        tick(); redirect = 1;
        push("memw_2", 4'b1111, 3'b000, 2'b01, 4'b0000, 3, 1);
        tick(); redirect = 0;
        push("memw_3", 4'b1111, 3'b000, 2'b01, 4'b0000, 4, 1);
        tick(); busy = 0;
        push("memw_release", 4'b0000, 3'b000, 2'b01, 4'b0000, 5, 1);
        tick();
        push("replay", 4'b0000, 3'b111, 2'b10, 4'b0000, 5, 1);
        tick();
        push("back_run", 4'b0000, 3'b000, 2'b00, 4'b0000, 5, 2);

        // Release without pending redirect behaves as RUN (load-use honoured).
        tick(); busy = 1;
        push("memw_np", 4'b1111, 3'b000, 2'b00, 4'b0000, 5, 2);
        tick(); busy = 0; load_use(5'd4);
        push("memw_np_lu", 4'b0011, 3'b010, 2'b01, 4'b0000, 6, 2);
        tick(); idle();
        push("memw_np_done", 4'b0000, 3'b000, 2'b00, 4'b0000, 7, 2);

        // Redirect in the RUN-busy cycle; busy during REPLAY is ignored until next cycle.
        tick(); busy = 1; redirect = 1;
        push("rb_redir", 4'b1111, 3'b000, 2'b00, 4'b0000, 7, 2);
        tick(); busy = 0; redirect = 0;
        push("rb_release", 4'b0000, 3'b000, 2'b01, 4'b0000, 8, 2);
        tick(); busy = 1;
        push("rb_replay_busy", 4'b0000, 3'b111, 2'b10, 4'b0000, 8, 2);
        tick();
        push("rb_run_busy", 4'b1111, 3'b000, 2'b00, 4'b0000, 8, 3);
        tick(); busy = 0;
        push("rb_release2", 4'b0000, 3'b000, 2'b01, 4'b0000, 9, 3);
        tick();
        push("rb_idle", 4'b0000, 3'b000, 2'b00, 4'b0000, 9, 3);

        // Saturation of the 4-bit stall counter.
        for (int i = 0; i < 20; i++) begin
            tick(); busy = 1;
            push("sat_busy", 4'b1111, 3'b000, (i == 0) ? 2'b00 : 2'b01, 4'b0000,
                 (9 + i > 15) ? 15 : 9 + i, 3);
        end
        tick(); redirect = 1;
        push("sat_redir", 4'b1111, 3'b000, 2'b01, 4'b0000, 15, 3);
        tick(); redirect = 0; reset = 0;
        push("rst_memw", 4'b0000, 3'b000, 2'b01, 4'b0000, 15, 3);
        tick(); reset = 1; busy = 0;
        push("post_rst", 4'b0000, 3'b000, 2'b00, 4'b0000, 0, 0);
        tick();
        push("no_replay", 4'b0000, 3'b000, 2'b00, 4'b0000, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
